// File: rtl/icache_bus_pkg.sv
// Shared bus constants and refill FSM states for the
// instruction cache and its memory-side refill bridge.
package icache_bus_pkg;

  localparam int ADDR_W         = 32;
  localparam int WORD_W         = 32;
  localparam int BLK_W          = 128;
  localparam int CACHE_BLK_SIZE = BLK_W;
  localparam int BEATS          = BLK_W / WORD_W;
  localparam int CNT_W          = $clog2(BEATS);
  localparam int OFF_W          = $clog2(BLK_W / 8);
  localparam int BYTE_SH        = $clog2(WORD_W / 8);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

endpackage

// File: rtl/refill_line_buf.sv
// One-entry tag/valid store of the last completed refill line.
// Ports: cpu_clk, cpu_rstn, upd, upd_tag (write); tag (lookup), hit.
module refill_line_buf #(
  parameter int TAG_W = 28
) (
  input  logic             cpu_clk,
  input  logic             cpu_rstn,
  input  logic             upd,
  input  logic [TAG_W-1:0] upd_tag,
  input  logic [TAG_W-1:0] tag,
  output logic             hit
);

  logic             vld_q;
  logic [TAG_W-1:0] tag_q;

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      vld_q <= 1'b0;
      tag_q <= '0;
    end else if (upd) begin
      vld_q <= 1'b1;
      tag_q <= upd_tag;
    end
  end

  assign hit = vld_q && (tag_q == tag);

endmodule

// File: rtl/icache_refill_bridge.sv
// I-cache line refill bridge: 4 pipelined word reads -> 128-bit line.
// Ports: cpu_* request side, dev_* line return, mem_* word bus.
// Option LAST_LINE_BUF_EN: last-line tag hit skips the memory reads.
module icache_refill_bridge #(
  parameter int ADDR_W = icache_bus_pkg::ADDR_W,
  parameter int WORD_W = icache_bus_pkg::WORD_W,
  parameter int BLK_W  = icache_bus_pkg::BLK_W
) (
  input  logic              cpu_clk,
  input  logic              cpu_rstn,
  input  logic [3:0]        cpu_ren,
  input  logic [ADDR_W-1:0] cpu_raddr,
  output logic              dev_rrdy,
  output logic              dev_rvalid,
  output logic [BLK_W-1:0]  dev_rdata,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [WORD_W-1:0] mem_rdata
);

  import icache_bus_pkg::*;

  localparam int TAG_W = ADDR_W - OFF_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] iss_q, iss_d;
  logic [CNT_W-1:0] rcv_q, rcv_d;
  logic [TAG_W-1:0] base_q, base_d;
  logic [BLK_W-1:0] line_q, line_d;
  logic [BLK_W-1:0] rdata_q;
  logic             fill_done;
  logic             hit;
  logic             unused_ok;

  assign unused_ok = ^cpu_raddr[OFF_W-1:0];

`ifdef LAST_LINE_BUF_EN
  refill_line_buf #(
    .TAG_W (TAG_W)
  ) u_buf (
    .cpu_clk  (cpu_clk),
    .cpu_rstn (cpu_rstn),
    .upd      (fill_done),
    .upd_tag  (base_q),
    .tag      (cpu_raddr[ADDR_W-1:OFF_W]),
    .hit      (hit)
  );
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_q <= S_IDLE;
      iss_q   <= '0;
      rcv_q   <= '0;
      base_q  <= '0;
      line_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      iss_q   <= iss_d;
      rcv_q   <= rcv_d;
      base_q  <= base_d;
      line_q  <= line_d;
      if (fill_done) rdata_q <= line_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    iss_d     = iss_q;
    rcv_d     = rcv_q;
    base_d    = base_q;
    line_d    = line_q;
    fill_done = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (|cpu_ren) begin
          base_d  = cpu_raddr[ADDR_W-1:OFF_W];
          iss_d   = '0;
          rcv_d   = '0;
          state_d = hit ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE, S_WAIT: begin
        if (state_q == S_ISSUE && mem_gnt) begin
          iss_d = iss_q + CNT_W'(1);
          if (iss_q == LAST) state_d = S_WAIT;
        end
        // Response after grant so a same-cycle last beat wins.
        if (mem_rvalid) begin
          line_d[32'(rcv_q)*WORD_W +: WORD_W] = mem_rdata;
          rcv_d = rcv_q + CNT_W'(1);
          if (rcv_q == LAST) begin
            state_d   = S_RESP;
            fill_done = 1'b1;
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign dev_rrdy   = (state_q == S_IDLE);
  assign dev_rvalid = (state_q == S_RESP);
  assign dev_rdata  = rdata_q;
  assign mem_req    = (state_q == S_ISSUE);
  assign mem_addr   = {base_q, {OFF_W{1'b0}}}
                    + (ADDR_W'(iss_q) << BYTE_SH);

endmodule

// File: tb/tb_icache_refill_bridge.sv
// Self-checking bench for icache_refill_bridge with a queue-based
// in-order memory model and random grant stalls / latency.
module tb_icache_refill_bridge;

  logic         cpu_clk = 1'b0;
  logic         cpu_rstn = 1'b0;
  logic [3:0]   cpu_ren = '0;
  logic [31:0]  cpu_raddr = '0;
  logic         dev_rrdy, dev_rvalid;
  logic [127:0] dev_rdata;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_gnt = 1'b0;
  logic         mem_rvalid = 1'b0;
  logic [31:0]  mem_rdata = '0;

  always #5 cpu_clk = ~cpu_clk;

  icache_refill_bridge dut (
    .cpu_clk    (cpu_clk),
    .cpu_rstn   (cpu_rstn),
    .cpu_ren    (cpu_ren),
    .cpu_raddr  (cpu_raddr),
    .dev_rrdy   (dev_rrdy),
    .dev_rvalid (dev_rvalid),
    .dev_rdata  (dev_rdata),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  typedef struct {
    logic [31:0] data;
    int          due;
  } rsp_t;

  rsp_t         pend[$];
  logic [31:0]  grants[$];
  int           cyc = 0;
  int           n_cmp = 0;
  int           n_err = 0;
  int           n_rvalid;
  int           rvalid_cyc;
  int           rrdy_cyc;
  logic [127:0] seen_line;
  logic [127:0] prev_line = '0;
  logic [31:0]  salt = 32'hA5A5_0000;
  bit           rand_gnt = 0;
  bit           ren_noise = 0;
  int           lat_max = 1;
  bit           prev_stall = 0;
  logic [31:0]  prev_addr = '0;

  // One clock cycle: drive inputs and observe at the falling edge,
  // let the memory model react to the rising edge.
  task automatic tick();
    bit          pop;
    bit          req_s;
    bit          gnt_s;
    logic [31:0] a;
    if (ren_noise && !dev_rrdy) begin
      cpu_ren   = 4'($urandom_range(1, 15));
      cpu_raddr = $urandom;
    end
    mem_gnt = rand_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
    pop = 0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = pend[0].data;
      pop = 1;
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
    end
    if (dev_rvalid) begin
      n_rvalid++;
      seen_line  = dev_rdata;
      rvalid_cyc = cyc;
    end
    if (rvalid_cyc >= 0 && rrdy_cyc < 0 && cyc > rvalid_cyc && dev_rrdy)
      rrdy_cyc = cyc;
    if (prev_stall && mem_req) begin
      n_cmp++;
      if (mem_addr !== prev_addr) begin
        n_err++;
        $display("FAIL addr_stable: mem_addr=%h required %h",
                 mem_addr, prev_addr);
      end
    end
    req_s = mem_req;
    gnt_s = mem_gnt;
    a     = mem_addr;
    prev_stall = req_s && !gnt_s;
    prev_addr  = a;
    if (req_s && gnt_s) grants.push_back(a);
    @(posedge cpu_clk);
    if (pop) pend.delete(0);
    if (req_s && gnt_s)
      pend.push_back('{a ^ salt,
        cyc + ((lat_max <= 1) ? 1 : int'($urandom_range(1, lat_max)))});
    cyc++;
    @(negedge cpu_clk);
    if (ren_noise) cpu_ren = '0;
  endtask

  task automatic run_req(input logic [31:0] addr, input bit exp_hit,
                         output int lat, output int rrdy_lat);
    logic [127:0] exp_line;
    logic [31:0]  base;
    int           t0;
    int           budget;
    int           exp_n;
    base = {addr[31:4], 4'h0};
    for (int i = 0; i < 4; i++)
      exp_line[32*i +: 32] = (base + 32'(4*i)) ^ salt;
    grants.delete();
    n_rvalid   = 0;
    rvalid_cyc = -1;
    rrdy_cyc   = -1;
    n_cmp++;
    if (dev_rrdy !== 1'b1) begin
      n_err++;
      $display("FAIL rrdy_before: dev_rrdy=%b required 1", dev_rrdy);
    end
    cpu_ren   = 4'($urandom_range(1, 15));
    cpu_raddr = addr;
    t0 = cyc;
    tick();
    cpu_ren   = '0;
    cpu_raddr = $urandom;
    budget = 0;
    while (n_rvalid == 0 && budget < 300) begin
      if (budget == 3) begin
        n_cmp++;
        if (dev_rdata !== prev_line) begin
          n_err++;
          $display("FAIL rdata_hold: dev_rdata=%h required %h",
                   dev_rdata, prev_line);
        end
      end
      tick();
      budget++;
    end
    for (int i = 0; i < 3; i++) tick();
    lat      = rvalid_cyc - t0;
    rrdy_lat = rrdy_cyc - t0;
    n_cmp++;
    if (n_rvalid !== 1) begin
      n_err++;
      $display("FAIL rvalid_pulses: count=%0d required 1", n_rvalid);
    end
    n_cmp++;
    if (seen_line !== exp_line) begin
      n_err++;
      $display("FAIL line: dev_rdata=%h required %h", seen_line, exp_line);
    end
    n_cmp++;
    if (dev_rdata !== exp_line) begin
      n_err++;
      $display("FAIL line_hold: dev_rdata=%h required %h",
               dev_rdata, exp_line);
    end
    exp_n = exp_hit ? 0 : 4;
    n_cmp++;
    if (grants.size() != exp_n) begin
      n_err++;
      $display("FAIL grant_count: grants=%0d required %0d",
               grants.size(), exp_n);
    end else begin
      for (int i = 0; i < exp_n; i++) begin
        n_cmp++;
        if (grants[i] !== base + 32'(4*i)) begin
          n_err++;
          $display("FAIL beat_addr%0d: mem_addr=%h required %h",
                   i, grants[i], base + 32'(4*i));
        end
      end
    end
    prev_line = exp_line;
  endtask

  task automatic test_reset();
    cpu_rstn = 1'b0;
    repeat (2) @(negedge cpu_clk);
    n_cmp++;
    if ({dev_rrdy, dev_rvalid, mem_req} !== 3'b100) begin
      n_err++;
      $display("FAIL reset_ctrl: rrdy/rvalid/req=%b required 100",
               {dev_rrdy, dev_rvalid, mem_req});
    end
    n_cmp++;
    if (dev_rdata !== '0 || mem_addr !== '0) begin
      n_err++;
      $display("FAIL reset_data: rdata=%h addr=%h required 0",
               dev_rdata, mem_addr);
    end
    cpu_rstn = 1'b1;
    @(negedge cpu_clk);
  endtask

  task automatic test_idle_noise();
    for (int i = 0; i < 4; i++) begin
      mem_gnt    = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = $urandom;
      @(posedge cpu_clk);
      cyc++;
      @(negedge cpu_clk);
      n_cmp++;
      if ({dev_rrdy, dev_rvalid, mem_req} !== 3'b100) begin
        n_err++;
        $display("FAIL idle_noise: rrdy/rvalid/req=%b required 100",
                 {dev_rrdy, dev_rvalid, mem_req});
      end
    end
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  task automatic test_directed();
    int lat, rl;
    rand_gnt = 0;
    lat_max  = 1;
    salt     = 32'hA5A5_0000;
    run_req(32'h0000_1234, 0, lat, rl);
    n_cmp++;
    if (lat != 6) begin
      n_err++;
      $display("FAIL rvalid_latency: T+%0d required T+6", lat);
    end
    n_cmp++;
    if (rl != 7) begin
      n_err++;
      $display("FAIL rrdy_return: T+%0d required T+7", rl);
    end
  endtask

  task automatic test_random_stalls();
    int lat, rl;
    rand_gnt = 1;
    lat_max  = 3;
    for (int k = 0; k < 6; k++) begin
      salt = $urandom;
      run_req($urandom, 0, lat, rl);
    end
  endtask

  task automatic test_ren_noise();
    int lat, rl;
    ren_noise = 1;
    for (int k = 0; k < 3; k++) begin
      salt = $urandom;
      run_req($urandom, 0, lat, rl);
    end
    ren_noise = 0;
    rand_gnt  = 0;
    lat_max   = 1;
  endtask

  task automatic test_reset_mid();
    int budget, lat, rl;
    salt = 32'h1111_0000;
    grants.delete();
    cpu_ren   = 4'hF;
    cpu_raddr = 32'h0000_1000;
    tick();
    cpu_ren = '0;
    budget = 0;
    while (grants.size() < 2 && budget < 20) begin
      tick();
      budget++;
    end
    n_cmp++;
    if (grants.size() < 2) begin
      n_err++;
      $display("FAIL pre_reset_grants: grants=%0d required 2",
               grants.size());
    end
    #2 cpu_rstn = 1'b0;
    pend.delete();
    prev_stall = 0;
    #1;
    n_cmp++;
    if ({dev_rrdy, mem_req} !== 2'b10 || dev_rdata !== '0) begin
      n_err++;
      $display("FAIL mid_reset: rrdy/req=%b rdata=%h required 10 / 0",
               {dev_rrdy, mem_req}, dev_rdata);
    end
    @(negedge cpu_clk);
    cpu_rstn  = 1'b1;
    prev_line = '0;
    @(negedge cpu_clk);
    salt = 32'hA5A5_0000;
    run_req(32'h0000_0040, 0, lat, rl);
  endtask

  task automatic test_repeat_line();
    int lat, rl;
    rand_gnt = 0;
    lat_max  = 1;
    salt     = 32'h5A5A_0000;
    run_req(32'h0000_2000, 0, lat, rl);
`ifdef LAST_LINE_BUF_EN
    run_req(32'h0000_2004, 1, lat, rl);
    n_cmp++;
    if (lat != 1) begin
      n_err++;
      $display("FAIL hit_latency: T+%0d required T+1", lat);
    end
    salt = 32'h0F0F_0000;
    run_req(32'h0000_2010, 0, lat, rl);
`else
    salt = 32'h0F0F_0000;
    run_req(32'h0000_2004, 0, lat, rl);
`endif
    n_cmp++;
    if (lat != 6) begin
      n_err++;
      $display("FAIL refill_latency: T+%0d required T+6", lat);
    end
  endtask

  initial begin
    test_reset();
    test_idle_noise();
    test_directed();
    test_random_stalls();
    test_ren_noise();
    test_reset_mid();
    test_repeat_line();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
